// File: rtl/meter_pkg.sv
// Shared constants, request encoding and double-dabble helper for the parking-meter scheduler.
package meter_pkg;

  localparam int COUNT_W   = 14;
  localparam int MAX_COUNT = 9999;
  localparam int FLASH_TH  = 200;
  localparam int PRESET_A  = 10;
  localparam int PRESET_B  = 205;
  localparam int ADD10     = 10;
  localparam int ADD180    = 180;
  localparam int ADD200    = 200;
  localparam int ADD550    = 550;
  localparam int NUM_REQ   = 7;

  // Index order doubles as grant priority: higher index wins.
  typedef enum logic [2:0] {
    REQ_ADD10    = 3'd0,
    REQ_ADD180   = 3'd1,
    REQ_ADD200   = 3'd2,
    REQ_ADD550   = 3'd3,
    REQ_TICK     = 3'd4,
    REQ_PRESET_A = 3'd5,
    REQ_PRESET_B = 3'd6
  } req_idx_e;

  typedef enum logic [1:0] {
    BCD_IDLE  = 2'd0,
    BCD_SHIFT = 2'd1,
    BCD_DONE  = 2'd2
  } bcd_state_e;

  function automatic logic [15:0] dd_step(input logic [15:0] bcd_in, input logic in_bit);
    logic [15:0] adj;
    adj = bcd_in;
    for (int d = 0; d < 4; d++) begin
      if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
    end
    return {adj[14:0], in_bit};
  endfunction

endpackage

// File: rtl/meter_bin2bcd.sv
// Iterative double-dabble converter: one bit per clk, W shifts, then a single DONE cycle.
module meter_bin2bcd
  import meter_pkg::*;
#(
  parameter int W = COUNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [15:0]  bcd
);

  localparam logic [3:0] LAST = 4'(W - 1);

  bcd_state_e   state_q, state_d;
  logic [W-1:0] bin_q, bin_d;
  logic [15:0]  bcd_q, bcd_d;
  logic [3:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      BCD_IDLE: begin
        if (start) begin
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = BCD_SHIFT;
        end
      end
      BCD_SHIFT: begin
        bcd_d = dd_step(bcd_q, bin_q[W-1]);
        bin_d = {bin_q[W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) state_d = BCD_DONE;
      end
      BCD_DONE: state_d = BCD_IDLE;
      default:  state_d = BCD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BCD_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != BCD_IDLE);
  assign done = (state_q == BCD_DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/meter_sched.sv
// Parking-meter request scheduler: pending flags, fixed-priority arbiter, shared
// saturating add/sub datapath, status flags and background BCD conversion.
module meter_sched
  import meter_pkg::*;
#(
  parameter int W = COUNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick_1hz,
  input  logic         add10,
  input  logic         add180,
  input  logic         add200,
  input  logic         add550,
  input  logic         preset_a,
  input  logic         preset_b,
  output logic [W-1:0] count,
  output logic [15:0]  bcd,
  output logic         bcd_valid,
  output logic         flash,
  output logic         expired,
  output logic         overrun
);

  localparam logic [W:0] MAX_EXT = (W+1)'(MAX_COUNT);

  logic [NUM_REQ-1:0] req_in, pend_q, pend_d, grant;
  logic [W-1:0]       count_q, count_d;
  logic [W:0]         add_val, sum;
  logic               overrun_q, overrun_d;
  logic [15:0]        bcd_q, bcd_d;
  logic               bcd_valid_q, bcd_valid_d;
  logic               dirty_q, dirty_d;
  logic               count_changed;
  logic               conv_start, conv_busy, conv_done;
  logic [15:0]        conv_bcd;

  always_comb begin
    req_in               = '0;
    req_in[REQ_ADD10]    = add10;
    req_in[REQ_ADD180]   = add180;
    req_in[REQ_ADD200]   = add200;
    req_in[REQ_ADD550]   = add550;
    req_in[REQ_TICK]     = tick_1hz;
    req_in[REQ_PRESET_A] = preset_a;
    req_in[REQ_PRESET_B] = preset_b;
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend_q[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  // A pulse on a source being granted this edge re-arms it rather than dropping.
  assign pend_d    = (pend_q & ~grant) | req_in;
  assign overrun_d = |(req_in & pend_q & ~grant);

  always_comb begin
    count_d = count_q;
    add_val = '0;
    sum     = '0;
    if (grant[REQ_PRESET_B]) begin
      count_d = W'(PRESET_B);
    end else if (grant[REQ_PRESET_A]) begin
      count_d = W'(PRESET_A);
    end else if (grant[REQ_TICK]) begin
      count_d = (count_q != '0) ? count_q - W'(1) : count_q;
    end else if (|grant) begin
      if (grant[REQ_ADD550])      add_val = (W+1)'(ADD550);
      else if (grant[REQ_ADD200]) add_val = (W+1)'(ADD200);
      else if (grant[REQ_ADD180]) add_val = (W+1)'(ADD180);
      else                        add_val = (W+1)'(ADD10);
      sum     = {1'b0, count_q} + add_val;
      count_d = (sum > MAX_EXT) ? MAX_EXT[W-1:0] : sum[W-1:0];
    end
  end

  assign count_changed = (count_d != count_q);
  assign conv_start    = dirty_q && !conv_busy;

  // dirty means the converter's snapshot no longer matches count.
  always_comb begin
    dirty_d = conv_start ? count_changed : (dirty_q | count_changed);
    bcd_d   = conv_done ? conv_bcd : bcd_q;
    if (count_changed)  bcd_valid_d = 1'b0;
    else if (conv_done) bcd_valid_d = !dirty_q;
    else                bcd_valid_d = bcd_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q      <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b1;
      dirty_q     <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      dirty_q     <= dirty_d;
    end
  end

  meter_bin2bcd #(.W(W)) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (conv_start),
    .bin     (count_q),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  assign count     = count_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign overrun   = overrun_q;
  assign flash     = (count_q < W'(FLASH_TH));
  assign expired   = (count_q == '0);

endmodule

// File: tb/tb_meter_sched.sv
// Scenario bench for meter_sched: per-edge stimulus/expectation steps queued and replayed.
module tb_meter_sched;
  import meter_pkg::*;

  typedef struct {
    logic [6:0] reqs;
    int         count;
    logic       ovr;
  } step_t;

  localparam logic [6:0] R_NONE  = 7'b0000000;
  localparam logic [6:0] R_ADD10 = 7'b0000001;
  localparam logic [6:0] R_A180  = 7'b0000010;
  localparam logic [6:0] R_A200  = 7'b0000100;
  localparam logic [6:0] R_A550  = 7'b0001000;
  localparam logic [6:0] R_TICK  = 7'b0010000;
  localparam logic [6:0] R_PB    = 7'b1000000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_1hz = 1'b0, add10 = 1'b0, add180 = 1'b0, add200 = 1'b0;
  logic        add550 = 1'b0, preset_a = 1'b0, preset_b = 1'b0;
  logic [13:0] count;
  logic [15:0] bcd;
  logic        bcd_valid, flash, expired, overrun;

  int    errors = 0;
  int    checks = 0;
  step_t sb[$];

  meter_sched dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_1hz  (tick_1hz),
    .add10     (add10),
    .add180    (add180),
    .add200    (add200),
    .add550    (add550),
    .preset_a  (preset_a),
    .preset_b  (preset_b),
    .count     (count),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .flash     (flash),
    .expired   (expired),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic int model_add(input int c, input int a);
    return (c + a > MAX_COUNT) ? MAX_COUNT : c + a;
  endfunction

  task automatic set_reqs(input logic [6:0] r);
    add10    = r[0];
    add180   = r[1];
    add200   = r[2];
    add550   = r[3];
    tick_1hz = r[4];
    preset_a = r[5];
    preset_b = r[6];
  endtask

  task automatic drive_edge(input logic [6:0] r);
    set_reqs(r);
    @(posedge clk);
    #1;
    set_reqs(R_NONE);
  endtask

  task automatic do_reset();
    set_reqs(R_NONE);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic load_count(input int target);
    int rem;
    do_reset();
    rem = target;
    while (rem >= ADD550) begin drive_edge(R_A550); rem -= ADD550; end
    while (rem >= ADD200) begin drive_edge(R_A200); rem -= ADD200; end
    while (rem >= ADD180) begin drive_edge(R_A180); rem -= ADD180; end
    while (rem >= ADD10)  begin drive_edge(R_ADD10); rem -= ADD10; end
    drive_edge(R_NONE);
    drive_edge(R_NONE);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_edge(R_A550);
    drive_edge(R_NONE);
    drive_edge(R_NONE);
    do_reset();
    checks++; if (count !== 14'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    checks++; if (flash !== 1'b1) begin errors++; $display("[TB] FAIL reset_flash: got %b want 1", flash); end
    checks++; if (expired !== 1'b1) begin errors++; $display("[TB] FAIL reset_expired: got %b want 1", expired); end
    checks++; if (bcd_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_bcd_valid: got %b want 1", bcd_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("[TB] FAIL reset_bcd: got %h want 0000", bcd); end
  endtask

  task automatic test_add550();
    step_t e;
    int    k;
    do_reset();
    sb.push_back('{R_A550, 0, 1'b0});
    sb.push_back('{R_NONE, model_add(0, ADD550), 1'b0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      drive_edge(e.reqs);
      checks++; if (count !== 14'(e.count)) begin errors++; $display("[TB] FAIL add550_count: got %0d want %0d", count, e.count); end
    end
    checks++; if (bcd_valid !== 1'b0) begin errors++; $display("[TB] FAIL add550_valid_drop: got %b want 0", bcd_valid); end
    k = 1;
    while (bcd_valid !== 1'b1 && k < 25) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++; if (k != 17) begin errors++; $display("[TB] FAIL add550_bcd_latency: got %0d edges want 17", k); end
    checks++; if (bcd !== 16'h0550) begin errors++; $display("[TB] FAIL add550_bcd: got %h want 0550", bcd); end
    checks++; if (flash !== 1'b0) begin errors++; $display("[TB] FAIL add550_flash: got %b want 0", flash); end
    checks++; if (expired !== 1'b0) begin errors++; $display("[TB] FAIL add550_expired: got %b want 0", expired); end
  endtask

  task automatic test_saturate();
    step_t e;
    load_count(9990);
    checks++; if (count !== 14'd9990) begin errors++; $display("[TB] FAIL sat_preload: got %0d want 9990", count); end
    sb.push_back('{R_ADD10 | R_A200, 9990, 1'b0});
    sb.push_back('{R_NONE, model_add(9990, ADD200), 1'b0});
    sb.push_back('{R_NONE, model_add(model_add(9990, ADD200), ADD10), 1'b0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      drive_edge(e.reqs);
      checks++; if (count !== 14'(e.count)) begin errors++; $display("[TB] FAIL sat_count: got %0d want %0d", count, e.count); end
      checks++; if (overrun !== e.ovr) begin errors++; $display("[TB] FAIL sat_overrun: got %b want %b", overrun, e.ovr); end
    end
  endtask

  task automatic test_tick_zero();
    step_t e;
    do_reset();
    repeat (3) sb.push_back('{R_TICK, 0, 1'b0});
    repeat (2) sb.push_back('{R_NONE, 0, 1'b0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      drive_edge(e.reqs);
      checks++; if (count !== 14'(e.count)) begin errors++; $display("[TB] FAIL tick0_count: got %0d want %0d", count, e.count); end
      checks++; if (expired !== 1'b1) begin errors++; $display("[TB] FAIL tick0_expired: got %b want 1", expired); end
    end
  endtask

  task automatic test_priority();
    step_t e;
    logic  exp_flash;
    load_count(300);
    sb.push_back('{R_PB | R_TICK | R_ADD10, 300, 1'b0});
    sb.push_back('{R_NONE, PRESET_B, 1'b0});
    sb.push_back('{R_NONE, PRESET_B - 1, 1'b0});
    sb.push_back('{R_NONE, model_add(PRESET_B - 1, ADD10), 1'b0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      exp_flash = (e.count < FLASH_TH);
      drive_edge(e.reqs);
      checks++; if (count !== 14'(e.count)) begin errors++; $display("[TB] FAIL prio_count: got %0d want %0d", count, e.count); end
      checks++; if (flash !== exp_flash) begin errors++; $display("[TB] FAIL prio_flash: got %b want %b", flash, exp_flash); end
      checks++; if (overrun !== e.ovr) begin errors++; $display("[TB] FAIL prio_overrun: got %b want %b", overrun, e.ovr); end
    end
  endtask

  task automatic test_back_to_back();
    step_t e;
    do_reset();
    sb.push_back('{R_ADD10, 0, 1'b0});
    sb.push_back('{R_ADD10, 10, 1'b0});
    sb.push_back('{R_ADD10, 20, 1'b0});
    sb.push_back('{R_NONE, 30, 1'b0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      drive_edge(e.reqs);
      checks++; if (count !== 14'(e.count)) begin errors++; $display("[TB] FAIL b2b_count: got %0d want %0d", count, e.count); end
      checks++; if (overrun !== e.ovr) begin errors++; $display("[TB] FAIL b2b_overrun: got %b want %b", overrun, e.ovr); end
    end
  endtask

  task automatic test_overrun();
    step_t e;
    do_reset();
    sb.push_back('{R_PB | R_A180, 0, 1'b0});
    sb.push_back('{R_A180, PRESET_B, 1'b1});
    sb.push_back('{R_NONE, model_add(PRESET_B, ADD180), 1'b0});
    sb.push_back('{R_NONE, model_add(PRESET_B, ADD180), 1'b0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      drive_edge(e.reqs);
      checks++; if (count !== 14'(e.count)) begin errors++; $display("[TB] FAIL ovr_count: got %0d want %0d", count, e.count); end
      checks++; if (overrun !== e.ovr) begin errors++; $display("[TB] FAIL ovr_overrun: got %b want %b", overrun, e.ovr); end
    end
  endtask

  task automatic test_dirty();
    step_t e;
    int    k;
    do_reset();
    sb.push_back('{R_ADD10, 0, 1'b0});
    sb.push_back('{R_NONE, 10, 1'b0});
    sb.push_back('{R_NONE, 10, 1'b0});
    sb.push_back('{R_NONE, 10, 1'b0});
    sb.push_back('{R_A200, 10, 1'b0});
    sb.push_back('{R_NONE, 210, 1'b0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      drive_edge(e.reqs);
      checks++; if (count !== 14'(e.count)) begin errors++; $display("[TB] FAIL dirty_count: got %0d want %0d", count, e.count); end
    end
    k = 0;
    while (bcd !== 16'h0010 && k < 25) begin @(posedge clk); #1; k++; end
    checks++; if (bcd !== 16'h0010) begin errors++; $display("[TB] FAIL dirty_stale_bcd: got %h want 0010", bcd); end
    checks++; if (bcd_valid !== 1'b0) begin errors++; $display("[TB] FAIL dirty_stale_valid: got %b want 0", bcd_valid); end
    k = 0;
    while (bcd_valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
    checks++; if (bcd_valid !== 1'b1) begin errors++; $display("[TB] FAIL dirty_restart_valid: got %b want 1 (timeout)", bcd_valid); end
    checks++; if (bcd !== 16'h0210) begin errors++; $display("[TB] FAIL dirty_restart_bcd: got %h want 0210", bcd); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_edge(R_A550);
    repeat (5) drive_edge(R_NONE);
    do_reset();
    checks++; if (count !== 14'd0) begin errors++; $display("[TB] FAIL rstmid_count: got %0d want 0", count); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("[TB] FAIL rstmid_bcd: got %h want 0000", bcd); end
    checks++; if (bcd_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_valid: got %b want 1", bcd_valid); end
    for (int i = 0; i < 20; i++) begin
      drive_edge(R_NONE);
      checks++;
      if (bcd !== 16'h0000 || bcd_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rstmid_idle: cycle %0d got bcd=%h valid=%b want 0000/1", i, bcd, bcd_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] meter_sched bench start");
    test_reset();
    test_add550();
    test_saturate();
    test_tick_zero();
    test_priority();
    test_back_to_back();
    test_overrun();
    test_dirty();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
